// File: rtl/ls_mem_unit.sv
// ls_mem_unit: byte-serial load/store responder between the LS execute stage
// and the 8-bit unified RAM port. Loads are assembled little-endian and
// sign/zero-extended before a one-cycle writeback strobe; stores complete
// silently. Optional feature macro: LS_MISALIGN_TRAP_EN adds a `misalign`
// output and rejects misaligned half/word requests without touching memory.
module ls_mem_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    input  logic [4:0]        req_target,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din,
    output logic              wb_en,
    output logic [4:0]        wb_target,
`ifdef LS_MISALIGN_TRAP_EN
    output logic              misalign,
`endif
    output logic [31:0]       wb_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_LAST,
        S_WB,
        S_TRAP
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [4:0]        target_q, target_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       asm_q, asm_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic              mem_wr_q, mem_wr_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              wb_en_q, wb_en_d;
    logic [4:0]        wb_target_q, wb_target_d;
    logic [31:0]       wb_data_q, wb_data_d;
`ifdef LS_MISALIGN_TRAP_EN
    logic              misalign_q, misalign_d;
`endif

    logic        req_trap;
    logic [1:0]  last_idx;
    logic [1:0]  cnt_p1;
    logic [1:0]  cnt_m1;
    logic [31:0] asm_full;
    logic [31:0] ext_val;

`ifdef LS_MISALIGN_TRAP_EN
    // Half on an odd address, or word (size 10/11) not on a 4-byte boundary.
    assign req_trap = ((req_op[1:0] == 2'b01) && req_addr[0]) ||
                      (req_op[1] && (req_addr[1:0] != 2'b00));
`else
    assign req_trap = 1'b0;
`endif

    // Index of the final byte: 0, 1 or 3 (reserved size behaves as a word).
    assign last_idx = (op_q[1:0] == 2'b00) ? 2'd0 :
                      (op_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
    assign cnt_p1   = cnt_q + 2'd1;
    assign cnt_m1   = cnt_q - 2'd1;

    // Final load byte arrives in LAST; merge it and extend from bit 8N-1.
    always_comb begin
        asm_full = asm_q;
        asm_full[{last_idx, 3'b000} +: 8] = mem_din;
        case (op_q[1:0])
            2'b00:   ext_val = op_q[2] ? {24'h0, asm_full[7:0]}
                                       : {{24{asm_full[7]}}, asm_full[7:0]};
            2'b01:   ext_val = op_q[2] ? {16'h0, asm_full[15:0]}
                                       : {{16{asm_full[15]}}, asm_full[15:0]};
            default: ext_val = asm_full;
        endcase
    end

    // Next-state and registered-output logic for the access sequencer.
    always_comb begin
        // NOTE: every _d gets its hold/default value first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        target_d    = target_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        mem_a_d     = mem_a_q;
        mem_wr_d    = 1'b0;
        mem_dout_d  = mem_dout_q;
        wb_en_d     = 1'b0;
        wb_target_d = wb_target_q;
        wb_data_d   = wb_data_q;
`ifdef LS_MISALIGN_TRAP_EN
        misalign_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d     = req_op;
                    addr_d   = req_addr[ADDR_W-1:0];
                    data_d   = req_data;
                    target_d = req_target;
                    cnt_d    = 2'd0;
                    if (req_trap) begin
`ifdef LS_MISALIGN_TRAP_EN
                        misalign_d = 1'b1;
`endif
                        state_d = S_TRAP;
                    end else begin
                        // Present byte 0 in the first ACCESS cycle.
                        state_d  = S_ACCESS;
                        mem_a_d  = req_addr[ADDR_W-1:0];
                        mem_wr_d = req_op[3];
                        if (req_op[3]) begin
                            mem_dout_d = req_data[7:0];
                        end
                    end
                end
            end
            S_ACCESS: begin
                // Read data lags its address by one cycle.
                if (!op_q[3] && (cnt_q != 2'd0)) begin
                    asm_d[{cnt_m1, 3'b000} +: 8] = mem_din;
                end
                if (cnt_q == last_idx) begin
                    state_d = op_q[3] ? S_IDLE : S_LAST;
                end else begin
                    cnt_d    = cnt_p1;
                    mem_a_d  = addr_q + ADDR_W'(cnt_p1);
                    mem_wr_d = op_q[3];
                    if (op_q[3]) begin
                        mem_dout_d = data_q[{cnt_p1, 3'b000} +: 8];
                    end
                end
                // Stores always run to completion; only loads can be dropped.
                if (flush && !op_q[3]) begin
                    state_d = S_IDLE;
                end
            end
            S_LAST: begin
                asm_d = asm_full;
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d     = S_WB;
                    wb_en_d     = 1'b1;
                    wb_target_d = target_q;
                    wb_data_d   = ext_val;
                end
            end
            S_WB:    state_d = S_IDLE;
            S_TRAP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value regardless of statement order.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            target_q    <= '0;
            cnt_q       <= '0;
            asm_q       <= '0;
            mem_a_q     <= '0;
            mem_wr_q    <= 1'b0;
            mem_dout_q  <= '0;
            wb_en_q     <= 1'b0;
            wb_target_q <= '0;
            wb_data_q   <= '0;
`ifdef LS_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            target_q    <= target_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            mem_a_q     <= mem_a_d;
            mem_wr_q    <= mem_wr_d;
            mem_dout_q  <= mem_dout_d;
            wb_en_q     <= wb_en_d;
            wb_target_q <= wb_target_d;
            wb_data_q   <= wb_data_d;
`ifdef LS_MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign mem_a     = mem_a_q;
    assign mem_wr    = mem_wr_q;
    assign mem_dout  = mem_dout_q;
    assign wb_en     = wb_en_q;
    assign wb_target = wb_target_q;
    assign wb_data   = wb_data_q;
`ifdef LS_MISALIGN_TRAP_EN
    assign misalign  = misalign_q;
`endif

endmodule

// File: tb/tb_ls_mem_unit.sv
// tb_ls_mem_unit: directed plus randomized load/store traffic against a
// byte-array reference memory. Expected writes, reads, writebacks and traps
// are queued with their due cycle at issue time; a negedge monitor pops them
// as the DUT presents them.
module tb_ls_mem_unit;

    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [4:0]  req_target = '0;
    logic        flush = 1'b0;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din = '0;
    logic        wb_en;
    logic [4:0]  wb_target;
    logic [31:0] wb_data;
`ifdef LS_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    ls_mem_unit #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_target (req_target),
        .flush      (flush),
        .mem_a      (mem_a),
        .mem_wr     (mem_wr),
        .mem_dout   (mem_dout),
        .mem_din    (mem_din),
        .wb_en      (wb_en),
        .wb_target  (wb_target),
`ifdef LS_MISALIGN_TRAP_EN
        .misalign   (misalign),
`endif
        .wb_data    (wb_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t wbq[$];
    exp_t wq[$];
    exp_t rq[$];
    exp_t mq[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus-side RAM (answers the DUT) and reference RAM (feeds the model).
    logic [7:0] bus_ram [0:65535];
    logic [7:0] ref_ram [0:65535];

    function automatic logic [7:0] init_byte(input int i);
        logic [15:0] a;
        a = 16'(i);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic preset(input logic [31:0] addr, input logic [7:0] v);
        bus_ram[addr[15:0]] = v;
        ref_ram[addr[15:0]] = v;
    endtask

    // RAM answers one cycle after the address; writes land on the edge.
    always @(posedge clk) begin
        mem_din <= bus_ram[mem_a[15:0]];
        if (mem_wr) bus_ram[mem_a[15:0]] <= mem_dout;
    end

    function automatic int size_n(input logic [3:0] op);
        return (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // Reference load: little-endian gather then extend from the top byte.
    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr);
        int n;
        logic [31:0] v;
        logic [31:0] a;
        n = size_n(op);
        v = '0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            v = v | (32'(ref_ram[a[15:0]]) << (8 * i));
        end
        if (n < 4 && !op[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (wb_en) begin
                if (wbq.size() == 0) check("unexpected_wb", 32'(wb_en), 32'd0);
                else begin
                    e = wbq.pop_front();
                    check("wb_cycle", 32'(cyc), 32'(e.cyc));
                    check("wb_target", 32'(wb_target), e.a);
                    check("wb_data", wb_data, e.d);
                end
            end
            if (mem_wr) begin
                if (wq.size() == 0) check("unexpected_write", 32'(mem_wr), 32'd0);
                else begin
                    e = wq.pop_front();
                    check("wr_cycle", 32'(cyc), 32'(e.cyc));
                    check("wr_addr", mem_a, e.a);
                    check("wr_byte", 32'(mem_dout), e.d);
                end
            end
            if (rq.size() != 0 && rq[0].cyc == cyc) begin
                e = rq.pop_front();
                check("rd_addr", mem_a, e.a);
                check("rd_not_write", 32'(mem_wr), 32'd0);
            end
`ifdef LS_MISALIGN_TRAP_EN
            if (misalign) begin
                if (mq.size() == 0) check("unexpected_misalign", 32'(misalign), 32'd0);
                else begin
                    e = mq.pop_front();
                    check("misalign_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
`endif
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_mem_a"}, mem_a, 32'd0);
        check({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
        check({tag, "_mem_dout"}, 32'(mem_dout), 32'd0);
        check({tag, "_wb_en"}, 32'(wb_en), 32'd0);
        check({tag, "_wb_target"}, 32'(wb_target), 32'd0);
        check({tag, "_wb_data"}, wb_data, 32'd0);
`ifdef LS_MISALIGN_TRAP_EN
        check({tag, "_misalign"}, 32'(misalign), 32'd0);
`endif
    endtask

    // Wait (bounded) until the unit is idle; returns 0 on timeout.
    task automatic wait_ready(output bit ok);
        int g;
        g = 0;
        while (!req_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        ok = req_ready;
        if (!ok) check("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    // Issue one request; fl = cycle (after accept) in which flush is pulsed,
    // 0 for none. Returns in the cycle the unit is expected idle again.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] tgt, input int fl);
        int n, base, r, nrd;
        bit mis, ok, dropped;
        logic [31:0] a;
        n = size_n(op);
`ifdef LS_MISALIGN_TRAP_EN
        mis = ((op[1:0] == 2'b01) && addr[0]) || ((op[1:0] >= 2'b10) && (addr[1:0] != 2'b00));
`else
        mis = 1'b0;
`endif
        req_op = op; req_addr = addr; req_data = data; req_target = tgt; req_valid = 1'b1;
        wait_ready(ok);
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush = 1'b0;
        base = cyc - 1;
        dropped = 1'b0;
        if (mis) begin
            mq.push_back('{base + 1, 32'd0, 32'd0});
            r = 2;
        end else if (op[3]) begin
            for (int i = 0; i < n; i++) begin
                a = addr + 32'(i);
                wq.push_back('{base + 1 + i, a, 32'(data[8*i +: 8])});
                ref_ram[a[15:0]] = data[8*i +: 8];
            end
            r = n + 1;
        end else begin
            dropped = (fl >= 1) && (fl <= n + 1);
            nrd = (dropped && fl < n) ? fl : n;
            for (int i = 0; i < nrd; i++) rq.push_back('{base + 1 + i, addr + 32'(i), 32'd0});
            if (dropped) r = fl + 1;
            else begin
                wbq.push_back('{base + n + 2, 32'(tgt), ref_load(op, addr)});
                r = n + 3;
            end
        end
        if (fl > 0 && !mis) begin
            repeat (fl - 1) @(posedge clk);
            #1 flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
        end
        while (cyc < base + r) begin
            @(negedge clk);
            if (cyc == base + r - 1) check("busy_before_done", 32'(req_ready), 32'd0);
        end
        check("ready_after_done", 32'(req_ready), 32'd1);
    endtask

    initial begin
        bit ok;
        int base, n, fl, gap;
        logic [3:0] op;
        logic [31:0] addr;
        for (int i = 0; i < 65536; i++) begin
            bus_ram[i] = init_byte(i);
            ref_ram[i] = init_byte(i);
        end
        #23;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Word load assembly and timing.
        preset(32'h100, 8'h78); preset(32'h101, 8'h56);
        preset(32'h102, 8'h34); preset(32'h103, 8'h12);
        issue(4'b0010, 32'h100, 32'h0, 5'd5, 0);
        // Signed and unsigned byte load of 0x80.
        preset(32'h200, 8'h80);
        issue(4'b0000, 32'h200, 32'h0, 5'd7, 0);
        issue(4'b0100, 32'h200, 32'h0, 5'd8, 0);
        // Half store.
        issue(4'b1001, 32'h300, 32'hDEADBEEF, 5'd0, 0);
        // Flushed word load, then a byte store back-to-back.
        issue(4'b0010, 32'h100, 32'h0, 5'd9, 3);
        issue(4'b1000, 32'h310, 32'h000000A7, 5'd0, 0);
        // Flush during WB does not suppress the strobe; reserved size is a word.
        issue(4'b0011, 32'h100, 32'h0, 5'd10, 6);
        // Address wrap across 2^32.
        issue(4'b1010, 32'hFFFF_FFFE, 32'hCAFEF00D, 5'd0, 0);
        issue(4'b0010, 32'hFFFF_FFFE, 32'h0, 5'd11, 0);
`ifdef LS_MISALIGN_TRAP_EN
        issue(4'b0010, 32'h102, 32'h0, 5'd12, 0);
`endif

        // Reset in the middle of a word store.
        req_op = 4'b1010; req_addr = 32'h400; req_data = 32'h11223344; req_target = '0;
        req_valid = 1'b1;
        wait_ready(ok);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        base = cyc - 1;
        wq.push_back('{base + 1, 32'h400, 32'h44});
        wq.push_back('{base + 2, 32'h401, 32'h33});
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midop_reset");
        @(negedge clk);
        rst_n = 1'b1;
        preset(32'h500, 8'hFF); preset(32'h501, 8'hFF);
        issue(4'b0001, 32'h500, 32'h0, 5'd13, 0);

        // Randomized traffic, including idle-cycle flush and flush in any load cycle.
        for (int k = 0; k < 300; k++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                flush = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            op = 4'($urandom);
            if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else addr = 32'h100 + 32'($urandom_range(0, 63));
            n = size_n(op);
            fl = 0;
            if ($urandom_range(0, 2) == 0) fl = op[3] ? $urandom_range(1, n) : $urandom_range(1, n + 2);
            issue(op, addr, $urandom, 5'($urandom), fl);
        end
        flush = 1'b0;
        repeat (4) @(negedge clk);

        check("pending_wb", 32'(wbq.size()), 32'd0);
        check("pending_writes", 32'(wq.size()), 32'd0);
        check("pending_reads", 32'(rq.size()), 32'd0);
        check("pending_misalign", 32'(mq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
